// File: rtl/spi_cmd_ctrl.sv
// Command layer behind the SPInew slave: decodes 16-bit commands, drives a 16x8 register bank,
// arms replies and long inbound payloads. Define SPI_CMD_TIMEOUT_EN to add a LONG_WAIT timeout.
module spi_cmd_ctrl #(
`ifdef SPI_CMD_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
`endif
    parameter logic [7:0] STATUS_TAG = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        received,
    input  logic [15:0] received_data,
    input  logic [63:0] long_dataIN,
    input  logic        busy,
    output logic        send_trigger,
    output logic [2:0]  SPI_MSG_TYPE,
    output logic [63:0] output_data,
    output logic        LongMsgComing,
    output logic [3:0]  InMsgByteCount,
    output logic        reg_wr,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata,
    output logic [63:0] payload,
    output logic        payload_valid,
    output logic [7:0]  err_cnt
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_EXEC       = 3'd1;
    localparam logic [2:0] S_TX_ARM     = 3'd2;
    localparam logic [2:0] S_TX_WAIT_HI = 3'd3;
    localparam logic [2:0] S_TX_WAIT_LO = 3'd4;
    localparam logic [2:0] S_LONG_WAIT  = 3'd5;

    logic [2:0]  state;
    logic        exec_wait;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [3:0]  arm_n;
    logic        arm_ok;
    logic        err_event;
    logic [63:0] long_mask;
`ifdef SPI_CMD_TIMEOUT_EN
    logic [31:0] timer;
    logic        timeout_hit;
`endif

    assign cmd_op   = received_data[15:12];
    assign cmd_addr = received_data[11:8];
    assign cmd_data = received_data[7:0];
    assign arm_n    = received_data[3:0];
    assign arm_ok   = (arm_n != 4'd0) && (arm_n <= 4'd8);

`ifdef SPI_CMD_TIMEOUT_EN
    // A message arriving on the last cycle still wins over the timeout.
    assign timeout_hit = (state == S_LONG_WAIT) && !received &&
                         (timer == TIMEOUT_CYCLES - 32'd1);
`endif

    always_comb begin
        long_mask = '0;
        for (int i = 0; i < 8; i++) begin
            long_mask[i*8 +: 8] = {8{4'(i) < InMsgByteCount}};
        end
    end

    always_comb begin
        err_event = 1'b0;
        if (received) begin
            case (state)
                S_IDLE: begin
                    case (cmd_op)
                        4'h1, 4'h2, 4'h3: err_event = 1'b0;
                        4'h4:             err_event = !arm_ok;
                        default:          err_event = 1'b1;
                    endcase
                end
                S_LONG_WAIT: err_event = 1'b0;
                default:     err_event = 1'b1;
            endcase
        end
`ifdef SPI_CMD_TIMEOUT_EN
        if (timeout_hit) begin
            err_event = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            exec_wait      <= 1'b0;
            send_trigger   <= 1'b0;
            SPI_MSG_TYPE   <= 3'b000;
            output_data    <= '0;
            LongMsgComing  <= 1'b0;
            InMsgByteCount <= 4'd0;
            reg_wr         <= 1'b0;
            reg_addr       <= 4'd0;
            reg_wdata      <= 8'd0;
            payload        <= '0;
            payload_valid  <= 1'b0;
            err_cnt        <= 8'd0;
`ifdef SPI_CMD_TIMEOUT_EN
            timer          <= 32'd0;
`endif
        end else begin
            reg_wr        <= 1'b0;
            payload_valid <= 1'b0;
            if (err_event && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (received) begin
                        case (cmd_op)
                            4'h1: begin
                                reg_wr    <= 1'b1;
                                reg_addr  <= cmd_addr;
                                reg_wdata <= cmd_data;
                            end
                            4'h2: begin
                                reg_addr  <= cmd_addr;
                                exec_wait <= 1'b0;
                                state     <= S_EXEC;
                            end
                            4'h3: begin
                                output_data  <= {40'h0, STATUS_TAG, err_cnt,
                                                 5'b0, LongMsgComing, 2'b0};
                                SPI_MSG_TYPE <= 3'b011;
                                state        <= S_TX_ARM;
                            end
                            4'h4: begin
                                if (arm_ok) begin
                                    LongMsgComing  <= 1'b1;
                                    InMsgByteCount <= arm_n;
                                    state          <= S_LONG_WAIT;
`ifdef SPI_CMD_TIMEOUT_EN
                                    timer          <= 32'd0;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // reg_rdata lags reg_addr by one cycle, so sample on the second EXEC cycle.
                S_EXEC: begin
                    if (!exec_wait) begin
                        exec_wait <= 1'b1;
                    end else begin
                        output_data  <= {48'h0, 4'h0, reg_addr, reg_rdata};
                        SPI_MSG_TYPE <= 3'b010;
                        state        <= S_TX_ARM;
                    end
                end
                S_TX_ARM: begin
                    send_trigger <= 1'b1;
                    state        <= S_TX_WAIT_HI;
                end
                S_TX_WAIT_HI: begin
                    if (busy) begin
                        send_trigger <= 1'b0;
                        state        <= S_TX_WAIT_LO;
                    end
                end
                S_TX_WAIT_LO: begin
                    if (!busy) begin
                        state <= S_IDLE;
                    end
                end
                S_LONG_WAIT: begin
                    if (received) begin
                        payload        <= long_dataIN & long_mask;
                        payload_valid  <= 1'b1;
                        LongMsgComing  <= 1'b0;
                        InMsgByteCount <= 4'd0;
                        state          <= S_IDLE;
                    end
`ifdef SPI_CMD_TIMEOUT_EN
                    else if (timeout_hit) begin
                        LongMsgComing  <= 1'b0;
                        InMsgByteCount <= 4'd0;
                        state          <= S_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with a small 16x8 register bank model.
// Exercises the LONG_WAIT timeout when built with SPI_CMD_TIMEOUT_EN.
module tb_spi_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        received = 1'b0;
    logic [15:0] received_data = 16'h0;
    logic [63:0] long_dataIN = 64'h0;
    logic        busy = 1'b0;
    logic        send_trigger;
    logic [2:0]  SPI_MSG_TYPE;
    logic [63:0] output_data;
    logic        LongMsgComing;
    logic [3:0]  InMsgByteCount;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h0;
    logic [63:0] payload;
    logic        payload_valid;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  bank [16];
    logic [15:0] long_cmd [3] = '{16'h4006, 16'h4008, 16'h4001};
    logic [3:0]  long_n   [3] = '{4'd6, 4'd8, 4'd1};
    logic [63:0] long_in  [3] = '{64'hFFFF_1122_3344_5566, 64'h0123_4567_89AB_CDEF,
                                  64'hFFFF_FFFF_FFFF_FF66};
    logic [63:0] long_exp [3] = '{64'h0000_1122_3344_5566, 64'h0123_4567_89AB_CDEF,
                                  64'h0000_0000_0000_0066};

`ifdef SPI_CMD_TIMEOUT_EN
    spi_cmd_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .CLK(CLK), .RST(RST), .received(received), .received_data(received_data),
        .long_dataIN(long_dataIN), .busy(busy), .send_trigger(send_trigger),
        .SPI_MSG_TYPE(SPI_MSG_TYPE), .output_data(output_data),
        .LongMsgComing(LongMsgComing), .InMsgByteCount(InMsgByteCount),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .payload(payload), .payload_valid(payload_valid),
        .err_cnt(err_cnt)
    );
`else
    spi_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .received(received), .received_data(received_data),
        .long_dataIN(long_dataIN), .busy(busy), .send_trigger(send_trigger),
        .SPI_MSG_TYPE(SPI_MSG_TYPE), .output_data(output_data),
        .LongMsgComing(LongMsgComing), .InMsgByteCount(InMsgByteCount),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .payload(payload), .payload_valid(payload_valid),
        .err_cnt(err_cnt)
    );
`endif

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (reg_wr) bank[reg_addr] <= reg_wdata;
        reg_rdata <= bank[reg_addr];
    end

    task send_cmd(input logic [15:0] cmd);
        @(negedge CLK);
        received_data = cmd;
        received = 1'b1;
        @(negedge CLK);
        received = 1'b0;
    endtask

    task wait_trigger(output int cyc);
        cyc = 0;
        while (send_trigger !== 1'b1 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task test_reset;
        logic [158:0] all_out;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        all_out = {send_trigger, SPI_MSG_TYPE, output_data, LongMsgComing, InMsgByteCount,
                   reg_wr, reg_addr, reg_wdata, payload, payload_valid, err_cnt};
        checks++;
        if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_outputs got %h exp 0", all_out); end
        RST = 1'b0;
    endtask

    task test_write;
        send_cmd(16'h1356);
        checks++;
        if (reg_wr !== 1'b1) begin errors++; $display("[TB] FAIL write_strobe got %b exp 1", reg_wr); end
        checks++;
        if (reg_addr !== 4'h3) begin errors++; $display("[TB] FAIL write_addr got %h exp 3", reg_addr); end
        checks++;
        if (reg_wdata !== 8'h56) begin errors++; $display("[TB] FAIL write_data got %h exp 56", reg_wdata); end
        checks++;
        if (send_trigger !== 1'b0) begin errors++; $display("[TB] FAIL write_no_reply got %b exp 0", send_trigger); end
        @(negedge CLK);
        checks++;
        if (reg_wr !== 1'b0) begin errors++; $display("[TB] FAIL write_pulse_len got %b exp 0", reg_wr); end
        send_cmd(16'h179C);
        @(negedge CLK);
    endtask

    task test_read;
        int cyc;
        send_cmd(16'h2700);
        wait_trigger(cyc);
        checks++;
        if (cyc >= 50) begin errors++; $display("[TB] FAIL read_trigger got timeout exp trigger"); end
        checks++;
        if (output_data !== 64'h079C) begin errors++; $display("[TB] FAIL read_data got %h exp 079c", output_data); end
        checks++;
        if (SPI_MSG_TYPE !== 3'b010) begin errors++; $display("[TB] FAIL read_type got %b exp 010", SPI_MSG_TYPE); end
        repeat (3) @(negedge CLK);
        checks++;
        if (send_trigger !== 1'b1) begin errors++; $display("[TB] FAIL trigger_held got %b exp 1", send_trigger); end
        busy = 1'b1;
        @(negedge CLK);
        checks++;
        if (send_trigger !== 1'b0) begin errors++; $display("[TB] FAIL trigger_drop got %b exp 0", send_trigger); end
        send_cmd(16'h1111);
        checks++;
        if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL overrun_err got %0d exp 1", err_cnt); end
        checks++;
        if (reg_wr !== 1'b0) begin errors++; $display("[TB] FAIL overrun_dropped got %b exp 0", reg_wr); end
        checks++;
        if (output_data !== 64'h079C) begin errors++; $display("[TB] FAIL read_data_held got %h exp 079c", output_data); end
        busy = 1'b0;
        @(negedge CLK);
        send_cmd(16'h1AEE);
        checks++;
        if (reg_wr !== 1'b1 || reg_addr !== 4'hA) begin
            errors++; $display("[TB] FAIL back_to_idle got wr=%b addr=%h exp wr=1 addr=a", reg_wr, reg_addr);
        end
    endtask

    task test_errors;
        int cyc;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        send_cmd(16'h4009);
        send_cmd(16'hF000);
        checks++;
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL bad_cmd_err got %0d exp 2", err_cnt); end
        checks++;
        if (LongMsgComing !== 1'b0 || send_trigger !== 1'b0) begin
            errors++; $display("[TB] FAIL bad_cmd_state got lmc=%b trig=%b exp 0 0", LongMsgComing, send_trigger);
        end
        send_cmd(16'h3000);
        wait_trigger(cyc);
        checks++;
        if (output_data !== 64'hA50200) begin errors++; $display("[TB] FAIL status_data got %h exp a50200", output_data); end
        checks++;
        if (SPI_MSG_TYPE !== 3'b011) begin errors++; $display("[TB] FAIL status_type got %b exp 011", SPI_MSG_TYPE); end
        busy = 1'b1;
        @(negedge CLK);
        busy = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task test_long;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(long_cmd[i]);
            checks++;
            if (LongMsgComing !== 1'b1 || InMsgByteCount !== long_n[i]) begin
                errors++; $display("[TB] FAIL long_arm%0d got lmc=%b n=%0d exp 1 %0d", i, LongMsgComing, InMsgByteCount, long_n[i]);
            end
            long_dataIN = long_in[i];
            send_cmd(16'hFFFF);
            checks++;
            if (payload_valid !== 1'b1 || payload !== long_exp[i]) begin
                errors++; $display("[TB] FAIL long_payload%0d got v=%b %h exp 1 %h", i, payload_valid, payload, long_exp[i]);
            end
            checks++;
            if (LongMsgComing !== 1'b0 || InMsgByteCount !== 4'd0) begin
                errors++; $display("[TB] FAIL long_clear%0d got lmc=%b n=%0d exp 0 0", i, LongMsgComing, InMsgByteCount);
            end
            @(negedge CLK);
            checks++;
            if (payload_valid !== 1'b0) begin errors++; $display("[TB] FAIL long_pulse%0d got %b exp 0", i, payload_valid); end
        end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL long_no_err got %0d exp 0", err_cnt); end
        send_cmd(16'h4000);
        checks++;
        if (err_cnt !== 8'd1 || LongMsgComing !== 1'b0) begin
            errors++; $display("[TB] FAIL long_zero got err=%0d lmc=%b exp 1 0", err_cnt, LongMsgComing);
        end
    endtask

    task test_reset_long;
        logic [158:0] all_out;
        send_cmd(16'h4003);
        checks++;
        if (LongMsgComing !== 1'b1) begin errors++; $display("[TB] FAIL rst_long_arm got %b exp 1", LongMsgComing); end
        RST = 1'b1;
        @(negedge CLK);
        all_out = {send_trigger, SPI_MSG_TYPE, output_data, LongMsgComing, InMsgByteCount,
                   reg_wr, reg_addr, reg_wdata, payload, payload_valid, err_cnt};
        checks++;
        if (all_out !== '0) begin errors++; $display("[TB] FAIL rst_long_outputs got %h exp 0", all_out); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task test_timeout;
        int cyc;
        logic saw_valid;
        saw_valid = 1'b0;
        send_cmd(16'h4004);
`ifdef SPI_CMD_TIMEOUT_EN
        cyc = 0;
        while (LongMsgComing === 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (payload_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (cyc != 50) begin errors++; $display("[TB] FAIL timeout_cycles got %0d exp 50", cyc); end
        checks++;
        if (err_cnt !== 8'd1 || InMsgByteCount !== 4'd0) begin
            errors++; $display("[TB] FAIL timeout_err got err=%0d n=%0d exp 1 0", err_cnt, InMsgByteCount);
        end
        checks++;
        if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_payload got %b exp 0", saw_valid); end
`else
        cyc = 0;
        repeat (60) @(negedge CLK);
        checks++;
        if (LongMsgComing !== 1'b1 || err_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL no_timeout got lmc=%b err=%0d exp 1 0", LongMsgComing, err_cnt);
        end
        long_dataIN = 64'hDEAD_BEEF_CAFE_F00D;
        send_cmd(16'h0000);
        saw_valid = payload_valid;
        checks++;
        if (saw_valid !== 1'b1 || payload !== 64'h0000_0000_CAFE_F00D || cyc != 0) begin
            errors++; $display("[TB] FAIL late_payload got v=%b %h exp 1 cafef00d", saw_valid, payload);
        end
`endif
    endtask

    task test_saturate;
        for (int i = 0; i < 260; i++) begin
            send_cmd(16'h5000);
        end
        checks++;
        if (err_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL err_saturate got %h exp ff", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_long();
        test_reset_long();
        test_timeout();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got hang exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
